// File: rtl/drygascon_pkg.sv
// Shared widths, bdi segment types and FSM encoding for the DryGASCON256 bdi block assembler.
package drygascon_pkg;
  localparam int CCW       = 32;
  localparam int CCWdiv8   = CCW / 8;
  localparam int BLK_W     = 128;
  localparam int WPB       = BLK_W / CCW;
  localparam int BLK_BYTES = BLK_W / 8;
  localparam int CNT_W     = $clog2(WPB);
  localparam int NB_W      = $clog2(BLK_BYTES + 1);
  localparam int PC_W      = $clog2(CCWdiv8 + 1);

  localparam logic [7:0] PAD_BYTE = 8'h01;

  localparam logic [3:0] HDR_AD       = 4'b0001;
  localparam logic [3:0] HDR_PT       = 4'b0100;
  localparam logic [3:0] HDR_CT       = 4'b0101;
  localparam logic [3:0] HDR_HASH_MSG = 4'b0111;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  function automatic logic [PC_W-1:0] popcount_bytes(input logic [CCWdiv8-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < CCWdiv8; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction
endpackage

// File: rtl/drygascon_bdi_block_assembler_if.sv
// bdi input stream and assembled-block output bundled for the block assembler.
interface drygascon_bdi_block_assembler_if;
  import drygascon_pkg::*;

  logic [CCW-1:0]     bdi;
  logic               bdi_valid;
  logic               bdi_ready;
  logic [CCWdiv8-1:0] bdi_valid_bytes;
  logic [CCWdiv8-1:0] bdi_pad_loc;
  logic               bdi_eot;
  logic               bdi_eoi;
  logic [3:0]         bdi_type;
  logic [BLK_W-1:0]   blk_data;
  logic               blk_valid;
  logic               blk_ready;
  logic [NB_W-1:0]    blk_nbytes;
  logic               blk_padded;
  logic [3:0]         blk_type;
  logic               blk_eot;
  logic               blk_eoi;
  logic               err;

  modport slave (
    input  bdi, bdi_valid, bdi_valid_bytes, bdi_pad_loc, bdi_eot, bdi_eoi, bdi_type, blk_ready,
    output bdi_ready, blk_data, blk_valid, blk_nbytes, blk_padded, blk_type, blk_eot, blk_eoi, err
  );

  modport master (
    output bdi, bdi_valid, bdi_valid_bytes, bdi_pad_loc, bdi_eot, bdi_eoi, bdi_type, blk_ready,
    input  bdi_ready, blk_data, blk_valid, blk_nbytes, blk_padded, blk_type, blk_eot, blk_eoi, err
  );
endinterface

// File: rtl/drygascon_byte_masker.sv
// Per-word byte cleanup: zero invalid bytes, force the pad byte, count valid bytes.
module drygascon_byte_masker
  import drygascon_pkg::*;
(
  input  logic [CCW-1:0]     word_i,
  input  logic [CCWdiv8-1:0] valid_bytes_i,
  input  logic [CCWdiv8-1:0] pad_loc_i,
  output logic [CCW-1:0]     word_o,
  output logic [PC_W-1:0]    nvalid_o,
  output logic               full_no_pad_o
);
  // Byte i of the word sits at the MSB end and is flagged by bit CCWdiv8-1-i.
  always_comb begin
    word_o = '0;
    for (int i = 0; i < CCWdiv8; i++) begin
      if (pad_loc_i[CCWdiv8-1-i]) begin
        word_o[CCW-1-8*i -: 8] = PAD_BYTE;
      end else if (valid_bytes_i[CCWdiv8-1-i]) begin
        word_o[CCW-1-8*i -: 8] = word_i[CCW-1-8*i -: 8];
      end else begin
        word_o[CCW-1-8*i -: 8] = 8'h00;
      end
    end
  end

  assign nvalid_o      = popcount_bytes(valid_bytes_i);
  assign full_no_pad_o = (&valid_bytes_i) && (pad_loc_i == '0);
endmodule

// File: rtl/drygascon_bdi_block_assembler.sv
// Packs bdi words into padded 128-bit rate blocks for the DryGASCON256 core.
// Optional DRYGASCON_BLK_BYPASS_EN lets a word enter the next block during the block handshake.
module drygascon_bdi_block_assembler
  import drygascon_pkg::*;
(
  input logic                           clk,
  input logic                           rst,
  drygascon_bdi_block_assembler_if.slave bus
);
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] data_q, data_d;
  logic [NB_W-1:0]  nbytes_q, nbytes_d;
  logic             padded_q, padded_d;
  logic [3:0]       type_q, type_d;
  logic             eot_q, eot_d;
  logic             eoi_q, eoi_d;
  logic             err_q, err_d;

  logic [CCW-1:0]   masked;
  logic [PC_W-1:0]  nvalid;
  logic             full_no_pad;
  logic             rdy, xfer, handshake, type_err, eoi_err, close;
  logic [CNT_W-1:0] slot;

  drygascon_byte_masker u_masker (
    .word_i        (bus.bdi),
    .valid_bytes_i (bus.bdi_valid_bytes),
    .pad_loc_i     (bus.bdi_pad_loc),
    .word_o        (masked),
    .nvalid_o      (nvalid),
    .full_no_pad_o (full_no_pad)
  );

`ifdef DRYGASCON_BLK_BYPASS_EN
  assign rdy = (state_q == ST_FILL) || bus.blk_ready;
`else
  assign rdy = (state_q == ST_FILL);
`endif

  assign handshake = (state_q == ST_FULL) && bus.blk_ready;
  assign xfer      = bus.bdi_valid && rdy;

  // Next-state: release on handshake first, so a bypassed word lands in a cleared block.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    nbytes_d = nbytes_q;
    padded_d = padded_q;
    type_d   = type_q;
    eot_d    = eot_q;
    eoi_d    = eoi_q;
    err_d    = err_q;
    type_err = 1'b0;
    eoi_err  = 1'b0;
    close    = 1'b0;
    slot     = cnt_q;

    if (handshake) begin
      state_d  = ST_FILL;
      data_d   = '0;
      nbytes_d = '0;
      slot     = '0;
    end else begin
      slot     = cnt_q;
    end

    if (xfer) begin
      type_err = (slot != '0) && (bus.bdi_type != type_q);
      eoi_err  = bus.bdi_eoi && !bus.bdi_eot;
      close    = (slot == CNT_W'(WPB - 1)) || bus.bdi_eot || type_err || eoi_err;
      if (slot == '0) begin
        type_d = bus.bdi_type;
      end else begin
        type_d = type_q;
      end
      data_d[BLK_W-1-int'(slot)*CCW -: CCW] = masked;
      nbytes_d = nbytes_d + NB_W'(nvalid);
      err_d    = err_q || type_err || eoi_err;
      if (close) begin
        // A full unpadded word closing early still owes the block its pad byte.
        if (full_no_pad && (slot != CNT_W'(WPB - 1))) begin
          data_d[BLK_W-1-(int'(slot)+1)*CCW -: 8] = PAD_BYTE;
        end else begin
          data_d = data_d;
        end
        state_d  = ST_FULL;
        cnt_d    = '0;
        padded_d = (nbytes_d < NB_W'(BLK_BYTES));
        eot_d    = bus.bdi_eot;
        eoi_d    = bus.bdi_eoi;
      end else begin
        state_d  = ST_FILL;
        cnt_d    = slot + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and block registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_FILL;
      cnt_q    <= '0;
      data_q   <= '0;
      nbytes_q <= '0;
      padded_q <= 1'b0;
      type_q   <= 4'h0;
      eot_q    <= 1'b0;
      eoi_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      nbytes_q <= nbytes_d;
      padded_q <= padded_d;
      type_q   <= type_d;
      eot_q    <= eot_d;
      eoi_q    <= eoi_d;
      err_q    <= err_d;
    end
  end

  assign bus.bdi_ready  = rdy;
  assign bus.blk_valid  = (state_q == ST_FULL);
  assign bus.blk_data   = data_q;
  assign bus.blk_nbytes = nbytes_q;
  assign bus.blk_padded = padded_q;
  assign bus.blk_type   = type_q;
  assign bus.blk_eot    = eot_q;
  assign bus.blk_eoi    = eoi_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_drygascon_bdi_block_assembler.sv
// Randomized and directed bench for the bdi block assembler against a byte-level reference model.
module tb_drygascon_bdi_block_assembler;
  import drygascon_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  drygascon_bdi_block_assembler_if bus ();

  drygascon_bdi_block_assembler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_err    = 0;
  int n_checks = 0;
  bit g_rdy    = 1'b0;

  // reference model: a block is a list of 16 bytes plus metadata
  bit         m_full;
  logic [7:0] m_fill [16];
  int         m_nw, m_nb;
  logic [3:0] m_type;
  bit         m_err;
  logic [7:0] e_bytes [16];
  int         e_nb;
  bit         e_pad, e_eot, e_eoi;
  logic [3:0] e_type;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready(input bit r);
`ifdef DRYGASCON_BLK_BYPASS_EN
    return !m_full || r;
`else
    return !m_full;
`endif
  endfunction

  function automatic logic [127:0] e_packed();
    logic [127:0] v = '0;
    for (int i = 0; i < 16; i++) v = {v[119:0], e_bytes[i]};
    return v;
  endfunction

  task automatic model_reset();
    m_full = 0; m_nw = 0; m_nb = 0; m_type = 4'h0; m_err = 0;
    e_nb = 0; e_pad = 0; e_eot = 0; e_eoi = 0; e_type = 4'h0;
    for (int i = 0; i < 16; i++) begin m_fill[i] = 8'h00; e_bytes[i] = 8'h00; end
  endtask

  task automatic model_cycle(input bit v, input logic [31:0] d, input logic [3:0] vb,
                             input logic [3:0] pad, input bit eot, input bit eoi,
                             input logic [3:0] t, input bit r);
    bit rdy = m_ready(r);
    bit terr, eerr;
    int slot;
    if (m_full && r) m_full = 0;
    if (v && rdy) begin
      slot = m_nw;
      terr = (m_nw > 0) && (t != m_type);
      if (m_nw == 0) m_type = t;
      for (int b = 0; b < 4; b++) begin
        if (pad[3-b])     m_fill[slot*4+b] = 8'h01;
        else if (vb[3-b]) m_fill[slot*4+b] = 8'((d >> (24 - 8*b)) & 32'hFF);
        else              m_fill[slot*4+b] = 8'h00;
        if (vb[3-b]) m_nb++;
      end
      eerr = eoi && !eot;
      m_err = m_err || terr || eerr;
      if (slot == 3 || eot || terr || eerr) begin
        if (slot < 3 && vb == 4'hF && pad == 4'h0) m_fill[(slot+1)*4] = 8'h01;
        for (int i = 0; i < 16; i++) begin e_bytes[i] = m_fill[i]; m_fill[i] = 8'h00; end
        e_nb = m_nb; e_pad = (m_nb < 16); e_type = m_type; e_eot = eot; e_eoi = eoi;
        m_full = 1; m_nw = 0; m_nb = 0;
      end else begin
        m_nw++;
      end
    end
  endtask

  task automatic step(input bit v, input logic [31:0] d, input logic [3:0] vb, input logic [3:0] pad,
                      input bit eot, input bit eoi, input logic [3:0] t, input bit r, output bit acc);
    bus.bdi_valid = v; bus.bdi = d; bus.bdi_valid_bytes = vb; bus.bdi_pad_loc = pad;
    bus.bdi_eot = eot; bus.bdi_eoi = eoi; bus.bdi_type = t; bus.blk_ready = r;
    #1;
    chk("bdi_ready", bus.bdi_ready, m_ready(r));
    acc = v && m_ready(r);
    model_cycle(v, d, vb, pad, eot, eoi, t, r);
    @(posedge clk); #1;
    chk("blk_valid", bus.blk_valid, m_full);
    chk("err", bus.err, m_err);
    if (m_full) begin
      chk("blk_data", bus.blk_data, e_packed());
      chk("blk_nbytes", bus.blk_nbytes, e_nb);
      chk("blk_padded", bus.blk_padded, e_pad);
      chk("blk_type", bus.blk_type, e_type);
      chk("blk_eot", bus.blk_eot, e_eot);
      chk("blk_eoi", bus.blk_eoi, e_eoi);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] vb, input logic [3:0] pad,
                      input bit eot, input bit eoi, input logic [3:0] t);
    bit acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) step(1'b1, d, vb, pad, eot, eoi, t, g_rdy, acc);
    chk("send_accepted", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, g_rdy, acc);
  endtask

  task automatic do_reset();
    bus.bdi_valid = 1'b0; bus.blk_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    chk("rst_valid", bus.blk_valid, 1'b0);
    chk("rst_ready", bus.bdi_ready, 1'b1);
    chk("rst_data", bus.blk_data, 128'h0);
    chk("rst_nbytes", bus.blk_nbytes, 5'd0);
    chk("rst_meta", {bus.blk_padded, bus.blk_type, bus.blk_eot, bus.blk_eoi, bus.err}, 8'h00);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] cur_t, vb, pad;
    logic [31:0] d;
    bit eot, eoi, acc;
    int k;
    rst = 1'b0;
    bus.bdi = '0; bus.bdi_valid = 1'b0; bus.bdi_valid_bytes = '0; bus.bdi_pad_loc = '0;
    bus.bdi_eot = 1'b0; bus.bdi_eoi = 1'b0; bus.bdi_type = '0; bus.blk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // four full AD words
    g_rdy = 1'b0;
    send(32'h00010203, 4'hF, 4'h0, 1'b0, 1'b0, HDR_AD);
    send(32'h04050607, 4'hF, 4'h0, 1'b0, 1'b0, HDR_AD);
    send(32'h08090A0B, 4'hF, 4'h0, 1'b0, 1'b0, HDR_AD);
    send(32'h0C0D0E0F, 4'hF, 4'h0, 1'b1, 1'b0, HDR_AD);
    chk("t1_valid", bus.blk_valid, 1'b1);
    chk("t1_data", bus.blk_data, 128'h000102030405060708090A0B0C0D0E0F);
    chk("t1_nbytes", bus.blk_nbytes, 5'd16);
    chk("t1_padded", bus.blk_padded, 1'b0);
    chk("t1_eot", bus.blk_eot, 1'b1);
    g_rdy = 1'b1; idle(1); g_rdy = 1'b0;

    // partial PT word with explicit pad
    send(32'hAABBCCDD, 4'hF, 4'h0, 1'b0, 1'b0, HDR_PT);
    send(32'hEEFF1234, 4'b1100, 4'b0010, 1'b1, 1'b0, HDR_PT);
    chk("t2_data", bus.blk_data, 128'hAABBCCDD_EEFF0100_00000000_00000000);
    chk("t2_nbytes", bus.blk_nbytes, 5'd6);
    chk("t2_padded", bus.blk_padded, 1'b1);

    // core stalls for 10 cycles with a word waiting
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h55667788, 4'hF, 4'h0, 1'b1, 1'b0, HDR_AD, 1'b0, acc);
      chk("hold_acc", acc, 1'b0);
      chk("hold_data", bus.blk_data, 128'hAABBCCDD_EEFF0100_00000000_00000000);
    end
    g_rdy = 1'b1;
    send(32'h55667788, 4'hF, 4'h0, 1'b1, 1'b0, HDR_AD);
    chk("hold_next", bus.blk_data, 128'h55667788_01000000_00000000_00000000);
    idle(1); g_rdy = 1'b0;

    // single full word closed by eot gets a pad word
    send(32'h11223344, 4'hF, 4'h0, 1'b1, 1'b0, HDR_HASH_MSG);
    chk("t3_data", bus.blk_data, 128'h11223344_01000000_00000000_00000000);
    chk("t3_nbytes", bus.blk_nbytes, 5'd4);
    chk("t3_padded", bus.blk_padded, 1'b1);
    g_rdy = 1'b1; idle(1); g_rdy = 1'b0;

    // empty final segment
    send(32'hDEADBEEF, 4'h0, 4'b1000, 1'b1, 1'b1, HDR_PT);
    chk("empty_data", bus.blk_data, 128'h01000000_00000000_00000000_00000000);
    chk("empty_meta", {bus.blk_nbytes, bus.blk_padded}, {5'd0, 1'b1});
    g_rdy = 1'b1; idle(1); g_rdy = 1'b0;

    // type change mid-block
    send(32'h01020304, 4'hF, 4'h0, 1'b0, 1'b0, HDR_AD);
    send(32'h05060708, 4'hF, 4'h0, 1'b0, 1'b0, HDR_AD);
    send(32'h090A0B0C, 4'hF, 4'h0, 1'b0, 1'b0, HDR_PT);
    chk("tc_err", bus.err, 1'b1);
    chk("tc_nbytes", bus.blk_nbytes, 5'd12);
    chk("tc_type", bus.blk_type, HDR_AD);
    g_rdy = 1'b1; idle(1); g_rdy = 1'b0;
    send(32'hCAFEF00D, 4'hF, 4'h0, 1'b1, 1'b0, HDR_AD);
    chk("tc_sticky", bus.err, 1'b1);
    g_rdy = 1'b1; idle(1); g_rdy = 1'b0;

    // reset abort at cnt=2, then a clean block
    send(32'hFFFFFFFF, 4'hF, 4'h0, 1'b0, 1'b0, HDR_CT);
    send(32'hEEEEEEEE, 4'hF, 4'h0, 1'b0, 1'b0, HDR_CT);
    do_reset();
    send(32'h10111213, 4'hF, 4'h0, 1'b0, 1'b0, HDR_AD);
    send(32'h14151617, 4'hF, 4'h0, 1'b0, 1'b0, HDR_AD);
    send(32'h18191A1B, 4'hF, 4'h0, 1'b0, 1'b0, HDR_AD);
    send(32'h1C1D1E1F, 4'hF, 4'h0, 1'b1, 1'b0, HDR_AD);
    chk("rs_data", bus.blk_data, 128'h101112131415161718191A1B1C1D1E1F);
    chk("rs_meta", {bus.blk_nbytes, bus.blk_type, bus.err}, {5'd16, HDR_AD, 1'b0});

    // randomized traffic with random stalls on both sides
    cur_t = HDR_PT;
    for (int w = 0; w < 400; w++) begin
      d = $urandom;
      k = $urandom_range(0, 4);
      vb = 4'(4'hF << (4 - k));
      pad = (k < 4 && $urandom_range(0, 1) == 1) ? 4'(4'b1000 >> k) : 4'h0;
      eot = (k < 4) ? 1'b1 : ($urandom_range(0, 3) == 0);
      eoi = (eot && $urandom_range(0, 7) == 0) || ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 3))
          0: cur_t = HDR_AD;
          1: cur_t = HDR_PT;
          2: cur_t = HDR_CT;
          default: cur_t = HDR_HASH_MSG;
        endcase
      end
      acc = 1'b0;
      for (int c = 0; c < 200 && !acc; c++)
        step($urandom_range(0, 3) != 0, d, vb, pad, eot, eoi, cur_t, $urandom_range(0, 2) != 0, acc);
      chk("rand_accepted", acc, 1'b1);
    end
    g_rdy = 1'b1; idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/drygascon_bdi_block_assembler.md
Name: drygascon_bdi_block_assembler

Overview:
- Sits between the LWC PreProcessor bdi stream and the DryGASCON256 CryptoCore permutation datapath.
- Packs CCW-bit bdi words into one 128-bit rate block, zeroes invalid bytes and applies DryGASCON padding (0x01 then zeros).
- Presents each block with its metadata to the core over a valid/ready handshake.

Parameters:
- CCW, 32, bdi word width in bits; must divide BLK_W.
- CCWdiv8, 4, bytes per bdi word (CCW/8).
- BLK_W, 128, rate block width in bits; WPB = BLK_W/CCW words per block (4 at defaults).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (rst=0 resets on the clock edge).
- bdi  in  CCW  input word; byte 0 is bdi[CCW-1 -: 8].
- bdi_valid  in  1  input word valid.
- bdi_ready  out  1  assembler accepts the word this cycle.
- bdi_valid_bytes  in  CCWdiv8  per-byte valid; MSB bit = byte 0.
- bdi_pad_loc  in  CCWdiv8  one-hot pad position, or 0 for none.
- bdi_eot  in  1  last word of the current type segment.
- bdi_eoi  in  1  last word of all input.
- bdi_type  in  4  segment type (AD, PT/CT, HASH_MSG, ...).
- blk_data  out  BLK_W  assembled block; word k at blk_data[BLK_W-1-k*CCW -: CCW].
- blk_valid  out  1  block ready for the core.
- blk_ready  in  1  core consumes the block.
- blk_nbytes  out  5  count of valid message bytes, 0..16.
- blk_padded  out  1  padding byte inserted (blk_nbytes < 16).
- blk_type  out  4  latched bdi_type of the block.
- blk_eot  out  1  block closed by eot.
- blk_eoi  out  1  block closed by eoi.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst=0 at a clock edge) forces the following, and aborts any partial or held block immediately, mid-operation included:
  - state FILL;
  - word count cnt=0;
  - blk_data=0, blk_nbytes=0;
  - blk_valid=0, blk_padded=0, blk_type=0, blk_eot=0, blk_eoi=0, err=0.
- States: FILL (accumulating words) and FULL (holding a block for the core).
- FILL:
  - bdi_ready=1 and blk_valid=0.
  - On a bdi_valid&&bdi_ready transfer:
    - the word is written to slot cnt;
    - bytes with valid_bytes=0 are zeroed;
    - the byte at pad_loc is forced to 0x01;
    - blk_nbytes += popcount(valid_bytes);
    - bdi_type is latched when cnt==0.
  - Block closes when cnt==WPB-1 or bdi_eot=1; next state is FULL, cnt=0.
  - Otherwise cnt increments.
- Close by eot on a slot below WPB-1:
  - the remaining slots are already zero;
  - if the closing word had every byte valid and pad_loc=0, byte 0 of slot cnt+1 is set to 0x01.
- Close on slot WPB-1 with every byte valid: no padding; blk_padded=0.
- blk_padded = (blk_nbytes < 16), registered at close.
- blk_eot and blk_eoi are registered from the closing word.
- FULL:
  - blk_valid=1 and bdi_ready=0 (without the optional feature).
  - All blk_* outputs are stable until blk_valid&&blk_ready.
  - On that handshake: next state FILL, blk_data cleared, blk_nbytes=0.
- Latency: one cycle from the closing transfer to blk_valid=1. Throughput without bypass: one block per WPB+1 cycles at best.
- Type change: bdi_type different from the latched type while cnt>0 is a protocol error.
  - err is set, sticky until reset.
  - The word is still stored.
  - The block is closed as if eot=1.
- Zero-valid word with eot (empty final segment):
  - accepted;
  - blk_nbytes is unchanged;
  - padding follows the pad_loc rules;
  - a block with blk_nbytes=0 and blk_padded=1 is legal when cnt==0.
- bdi_eoi without bdi_eot is a protocol error: err is set and the block closes.

Optional Feature:
- Macro: DRYGASCON_BLK_BYPASS_EN.
- Defined:
  - in FULL, bdi_ready = blk_ready;
  - a word transferred in the same cycle as the block handshake is written to slot 0 of the new block, with its type latched;
  - the state goes to FILL with cnt=1, or stays FULL if that word closes the block;
  - throughput is one block per WPB cycles.
- Undefined: bdi_ready=0 throughout FULL, as described above.

Decomposition:
- Shared package drygascon_pkg holds:
  - BLK_W, WPB, PAD_BYTE=8'h01;
  - the bdi_type localparams (HDR_AD, HDR_PT, HDR_CT, HDR_HASH_MSG);
  - the state encoding ST_FILL / ST_FULL.
- One natural sub-module, drygascon_byte_masker: combinational per-word zeroing and pad insertion, plus popcount of valid bytes.
- The FSM, slot write and metadata registers stay in the top module.

Test Plan:
- Four full AD words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F, with eot on the 4th -> blk_valid one cycle later; blk_data=0x000102030405060708090A0B0C0D0E0F; nbytes=16; padded=0; eot=1.
- Two PT words, the 2nd with valid_bytes=4'b1100, pad_loc=4'b0010, eot=1 -> blk_data=0xAABBCCDD_EEFF0100_00000000_00000000; nbytes=6; padded=1.
- One full word 0x11223344 with eot, pad_loc=0 -> slot1 byte0=0x01; data=0x11223344_01000000_0...; nbytes=4; padded=1.
- blk_ready held low for 10 cycles in FULL -> blk_* stable, bdi_ready=0, no word lost; release -> next word lands in slot 0.
- Type change AD->PT at cnt=2 -> err=1 sticky; block closes with nbytes=12 and blk_type=AD; err clears only on rst=0.
- rst=0 asserted at cnt=2, then a fresh 4-word block -> no residue from the aborted block. With DRYGASCON_BLK_BYPASS_EN defined: back-to-back blocks at one block per 4 cycles.
